// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mul_div_unit_pkg
//  Purpose : Shared CPU parameter package for the multiply/divide unit.
//            It holds the HI/LO unit op encodings, the cycle-counter width,
//            the controller state type and a small op-class helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mul_div_unit_pkg;

  // Multiply/divide unit op encodings (3-bit op field). 6 and 7 are reserved.
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // Busy counter covers cycle counts up to 255.
  localparam int MDU_CNT_W = 8;

  typedef enum logic [0:0] {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // The four multi-cycle ops are exactly the encodings with op[2] clear.
  function automatic logic mdu_is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mul_div_unit
//  Purpose : MIPS-style HI/LO multiply/divide unit. MULT/MULTU/DIV/DIVU are
//            evaluated at acceptance into pending registers and committed to
//            HI/LO after a fixed busy period; MTHI/MTLO write directly.
//  Ports   : clk    - clock, rising edge
//            reset  - asynchronous reset, active low
//            start  - request qualifier for op
//            op     - operation select (see mul_div_unit_pkg)
//            a, b   - operands (a is also MTHI/MTLO source data)
//            busy   - multiply/divide in flight
//            done   - one-cycle pulse after HI/LO take a mult/div result
//            hi, lo - HI and LO registers
//  Rev     : 1.0  initial release
// ============================================================================
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // --------------------------------------------------------------------------
  if (MULT_CYCLES < 1 || MULT_CYCLES > 255) begin : g_bad_mult_cycles
    $error("mul_div_unit: MULT_CYCLES must be in 1..255");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div_cycles
    $error("mul_div_unit: DIV_CYCLES must be in 1..255");
  end

  localparam logic [MDU_CNT_W-1:0] c_mult_load = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] c_div_load  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] c_cnt_one   = MDU_CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mdu_state_e             state_q;
  logic [MDU_CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]       hi_q;
  logic [WIDTH-1:0]       lo_q;
  logic                   done_q;
  logic [WIDTH-1:0]       pend_hi_q;
  logic [WIDTH-1:0]       pend_lo_q;
  logic                   pend_wr_q;

  // Values to be captured into the pending registers at acceptance
  logic [WIDTH-1:0]       pend_hi_d;
  logic [WIDTH-1:0]       pend_lo_d;
  logic                   pend_wr_d;
  logic [MDU_CNT_W-1:0]   cnt_load_d;

  // --------------------------------------------------------------------------
  // Arithmetic datapath (operates on the live operands; results are only
  // sampled at the accepting edge, so later operand changes are harmless)
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0]     w_prod_s;
  logic [2*WIDTH-1:0]     w_prod_u;
  logic                   w_b_zero;
  logic [WIDTH-1:0]       w_u_den;
  logic [WIDTH-1:0]       w_u_quot;
  logic [WIDTH-1:0]       w_u_rem;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic [WIDTH-1:0]       w_s_den;
  logic [WIDTH-1:0]       w_sq_mag;
  logic [WIDTH-1:0]       w_sr_mag;
  logic [WIDTH-1:0]       w_s_quot;
  logic [WIDTH-1:0]       w_s_rem;

  // Sign-extending both factors to 2*WIDTH makes the low 2*WIDTH bits of an
  // unsigned multiply equal the two's-complement signed product.
  assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // A zero divisor is replaced by one so the dividers never see zero; the
  // result is discarded in that case anyway.
  assign w_b_zero = (b == '0);
  assign w_u_den  = w_b_zero ? WIDTH'(1) : b;
  assign w_u_quot = a / w_u_den;
  assign w_u_rem  = a % w_u_den;

  // Signed divide via magnitudes. The magnitude of the most-negative value
  // is 2^(WIDTH-1), which still fits unsigned in WIDTH bits; dividing it by
  // one and re-negating wraps back to the most-negative value with a zero
  // remainder, which is exactly the required MIN / -1 result.
  assign w_a_mag  = a[WIDTH-1] ? -a : a;
  assign w_b_mag  = b[WIDTH-1] ? -b : b;
  assign w_s_den  = w_b_zero ? WIDTH'(1) : w_b_mag;
  assign w_sq_mag = w_a_mag / w_s_den;
  assign w_sr_mag = w_a_mag % w_s_den;
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign w_s_quot = (a[WIDTH-1] ^ b[WIDTH-1]) ? -w_sq_mag : w_sq_mag;
  assign w_s_rem  = a[WIDTH-1] ? -w_sr_mag : w_sr_mag;

  always_comb begin
    pend_hi_d  = w_prod_s[2*WIDTH-1:WIDTH];
    pend_lo_d  = w_prod_s[WIDTH-1:0];
    pend_wr_d  = 1'b1;
    cnt_load_d = c_mult_load;
    case (op)
      MDU_MULTU: begin
        pend_hi_d  = w_prod_u[2*WIDTH-1:WIDTH];
        pend_lo_d  = w_prod_u[WIDTH-1:0];
      end
      MDU_DIV: begin
        pend_hi_d  = w_s_rem;
        pend_lo_d  = w_s_quot;
        pend_wr_d  = ~w_b_zero;
        cnt_load_d = c_div_load;
      end
      MDU_DIVU: begin
        pend_hi_d  = w_u_rem;
        pend_lo_d  = w_u_quot;
        pend_wr_d  = ~w_b_zero;
        cnt_load_d = c_div_load;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Controller: IDLE accepts requests, BUSY counts down and commits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            if (mdu_is_muldiv(op)) begin
              pend_hi_q <= pend_hi_d;
              pend_lo_q <= pend_lo_d;
              pend_wr_q <= pend_wr_d;
              cnt_q     <= cnt_load_d;
              state_q   <= MDU_BUSY;
            end else if (op == MDU_MTHI) begin
              hi_q <= a;
            end else if (op == MDU_MTLO) begin
              lo_q <= a;
            end
          end
        end
        MDU_BUSY: begin
          // The counter holds N at acceptance; the edge that sees 1 is EN.
          if (cnt_q == c_cnt_one) begin
            cnt_q   <= '0;
            state_q <= MDU_IDLE;
            done_q  <= 1'b1;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - c_cnt_one;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mul_div_unit
//  Purpose : Self-checking bench for mul_div_unit. Two instances (default
//            latencies, and MULT_CYCLES=1 / DIV_CYCLES=2) share one stimulus
//            stream and are compared every cycle against a timestamp-based
//            behavioural model; literal expectations pin known results.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     op    = 3'd0;
  logic [W-1:0]   a     = '0;
  logic [W-1:0]   b     = '0;

  logic           dut_busy [2];
  logic           dut_done [2];
  logic [W-1:0]   dut_hi   [2];
  logic [W-1:0]   dut_lo   [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(dut_busy[0]), .done(dut_done[0]), .hi(dut_hi[0]), .lo(dut_lo[0])
  );

  mul_div_unit #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(dut_busy[1]), .done(dut_done[1]), .hi(dut_hi[1]), .lo(dut_lo[1])
  );

  // --------------------------------------------------------------------------
  // Behavioural model: results from plain 64-bit arithmetic, timing from an
  // edge timestamp (op accepted at edge c completes at edge c+N).
  // --------------------------------------------------------------------------
  longint       cyc = 0;
  bit           m_act  [2];
  bit           m_done [2];
  bit           m_wr   [2];
  longint       m_end  [2];
  logic [W-1:0] m_hi   [2];
  logic [W-1:0] m_lo   [2];
  logic [W-1:0] m_phi  [2];
  logic [W-1:0] m_plo  [2];

  function automatic int lat(input int k, input logic [2:0] o);
    if (o == MDU_MULT || o == MDU_MULTU) return (k == 0) ? 5 : 1;
    return (k == 0) ? 10 : 2;
  endfunction

  task automatic predict(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output bit wr,
                         output logic [W-1:0] h, output logic [W-1:0] l);
    longint          sx, sy, p, q, r;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    wr = 1'b1;
    h  = '0;
    l  = '0;
    case (o)
      MDU_MULT: begin
        p = sx * sy;
        h = p[63:32];
        l = p[31:0];
      end
      MDU_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        h  = pu[63:32];
        l  = pu[31:0];
      end
      MDU_DIV: begin
        if (y == '0) wr = 1'b0;
        else begin
          q = sx / sy;
          r = sx % sy;
          h = r[31:0];
          l = q[31:0];
        end
      end
      default: begin
        if (y == '0) wr = 1'b0;
        else begin
          h = x % y;
          l = x / y;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k]  = 1'b0;
        m_done[k] = 1'b0;
        m_hi[k]   = '0;
        m_lo[k]   = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 1'b0;
        if (m_act[k]) begin
          if (cyc == m_end[k]) begin
            m_act[k]  = 1'b0;
            m_done[k] = 1'b1;
            if (m_wr[k]) begin
              m_hi[k] = m_phi[k];
              m_lo[k] = m_plo[k];
            end
          end
        end else if (start) begin
          if (op <= MDU_DIVU) begin
            predict(op, a, b, m_wr[k], m_phi[k], m_plo[k]);
            m_act[k] = 1'b1;
            m_end[k] = cyc + longint'(lat(k, op));
          end else if (op == MDU_MTHI) begin
            m_hi[k] = a;
          end else if (op == MDU_MTLO) begin
            m_lo[k] = a;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp_v);
    end
  endtask

  // Advance one cycle and compare both DUTs against the model.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d busy", k), W'(dut_busy[k]), W'(m_act[k]));
        chk($sformatf("dut%0d done", k), W'(dut_done[k]), W'(m_done[k]));
        chk($sformatf("dut%0d hi", k), dut_hi[k], m_hi[k]);
        chk($sformatf("dut%0d lo", k), dut_lo[k], m_lo[k]);
      end
    end
  endtask

  task automatic step(input logic s, input logic [2:0] o,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    start = s;
    op    = o;
    a     = x;
    b     = y;
    tick();
  endtask

  // Idle cycle with scrambled operands (start low).
  task automatic idle();
    step(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dut_busy[0] || dut_busy[1]) && n < 400) begin
      idle();
      n++;
    end
    n_cmp++;
    if (dut_busy[0] || dut_busy[1]) begin
      n_err++;
      $display("FAIL wait_idle: busy still high after %0d cycles", n);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int          cnt;
    bit          saw_done;
    logic [2:0]  ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("reset busy", W'(dut_busy[0]), '0);
    chk("reset done", W'(dut_done[0]), '0);
    chk("reset hi", dut_hi[0], '0);
    chk("reset lo", dut_lo[0], '0);

    // Release reset and issue MTLO so it lands on the first live edge.
    reset = 1'b1;
    step(1'b1, MDU_MTLO, 32'h1234_5678, 32'h0);
    chk("mtlo lo", dut_lo[0], 32'h1234_5678);
    chk("mtlo busy", W'(dut_busy[0]), '0);
    chk("mtlo done", W'(dut_done[0]), '0);

    // MULT -3 * 7 = -21, busy for exactly five sampled cycles.
    step(1'b1, MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mult busy c%0d", i), W'(dut_busy[0]), 32'd1);
      chk($sformatf("mult done c%0d", i), W'(dut_done[0]), 32'd0);
      idle();
    end
    chk("mult busy end", W'(dut_busy[0]), 32'd0);
    chk("mult done end", W'(dut_done[0]), 32'd1);
    chk("mult hi", dut_hi[0], 32'hFFFF_FFFF);
    chk("mult lo", dut_lo[0], 32'hFFFF_FFEB);
    idle();
    chk("mult done 1-cycle", W'(dut_done[0]), 32'd0);
    wait_idle();

    // DIVU 100/7, then DIV -7/2.
    step(1'b1, MDU_DIVU, 32'd100, 32'd7);
    wait_idle();
    chk("divu lo", dut_lo[0], 32'd14);
    chk("divu hi", dut_hi[0], 32'd2);
    step(1'b1, MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div lo", dut_lo[0], 32'hFFFF_FFFD);
    chk("div hi", dut_hi[0], 32'hFFFF_FFFF);

    // Most-negative / -1.
    step(1'b1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("divmin lo", dut_lo[0], 32'h8000_0000);
    chk("divmin hi", dut_hi[0], 32'h0);

    // Fresh reset, then MULTU 3*4 with DIV and MTHI attempted while busy.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, MDU_MULTU, 32'd3, 32'd4);
    idle();
    idle();
    step(1'b1, MDU_DIV, 32'd50, 32'd5);
    step(1'b1, MDU_MTHI, 32'h0000_AAAA, 32'd0);
    start = 1'b0;
    wait_idle();
    chk("multu hi", dut_hi[0], 32'h0);
    chk("multu lo", dut_lo[0], 32'd12);

    // Divide by zero keeps HI/LO but runs the full busy period.
    step(1'b1, MDU_MTHI, 32'h11, 32'd0);
    step(1'b1, MDU_MTLO, 32'h22, 32'd0);
    step(1'b1, MDU_DIV, 32'd5, 32'd0);
    cnt = 0;
    while (dut_busy[0] && cnt < 50) begin
      cnt++;
      idle();
    end
    chk("div0 busy cycles", W'(cnt), 32'd10);
    chk("div0 done", W'(dut_done[0]), 32'd1);
    chk("div0 hi", dut_hi[0], 32'h11);
    chk("div0 lo", dut_lo[0], 32'h22);
    wait_idle();

    // start held high: the request at EN is rejected, E(N+1) accepts.
    step(1'b1, MDU_MULT, 32'd2, 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, MDU_MULTU, 32'd5, 32'd6);
    chk("backtoback lo1", dut_lo[0], 32'd6);
    chk("backtoback busy EN", W'(dut_busy[0]), 32'd0);
    step(1'b1, MDU_MULTU, 32'd5, 32'd6);
    chk("backtoback busy EN+1", W'(dut_busy[0]), 32'd1);
    start = 1'b0;
    wait_idle();
    chk("backtoback lo2", dut_lo[0], 32'd30);

    // Reset in the middle of a DIVU.
    step(1'b1, MDU_DIVU, 32'd1000, 32'd3);
    idle();
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("rst mid busy", W'(dut_busy[0]), 32'd0);
    chk("rst mid hi", dut_hi[0], 32'd0);
    chk("rst mid lo", dut_lo[0], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      idle();
      if (dut_done[0]) saw_done = 1'b1;
    end
    chk("rst no done", W'(saw_done), 32'd0);

    // Randomized traffic with corner operands mixed in.
    for (int i = 0; i < 400; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      step(1'($urandom_range(0, 1)), ro, ra, rb);
    end
    start = 1'b0;
    wait_idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_mul_div_unit
`default_nettype wire
